systolic_seq_ctrl: RTL and testbench

Sequencer for the 3x3 weight-stationary PE systolic array: accepts one activation matrix A and one weight matrix W per job, loads W into the array, and streams A into the array rows with diagonal skew. It also captures the bottom-of-column partial sums into a result matrix C = A x W.
Sits between the host/job interface and the PE array in the TPU top level; the PE array itself is outside this block.

---
 rtl/systolic_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer for an NxN weight-stationary systolic array.
// Latches A and W per job, loads W into the array and streams A with a diagonal
// skew. It captures the bottom-of-column partial sums into the result matrix C.
module systolic_seq_ctrl #(
  parameter int N   = 3,
  parameter int DW  = 8,
  parameter int AW  = 24,
  parameter int LAT = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] w_mat,
  output logic              busy,
  output logic              done,
  output logic              w_load,
  output logic [N*N*DW-1:0] w_bus,
  output logic [N*DW-1:0]   act_row,
  output logic              act_vld,
  input  logic [N*AW-1:0]   col_sum,
  output logic [N*N*AW-1:0] c_mat,
  output logic              c_valid
);

  localparam int RUN_LEN = 2*N - 2 + LAT + 1;
  localparam int KW      = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [N*N*DW-1:0] a_q, a_d;
  logic [N*N*DW-1:0] w_q, w_d;
  logic [N*DW-1:0]   act_q, act_d;
  logic              vld_q, vld_d;
  logic [N*N*AW-1:0] c_q, c_d;
  logic              cv_q, cv_d;
  logic              accept;

  // Row r of the skewed activation front for RUN cycle k: A[k-r][r] or zero.
  function automatic logic [N*DW-1:0] skew_row(input logic [N*N*DW-1:0] a, input int k);
    logic [N*DW-1:0] row;
    row = '0;
    for (int r = 0; r < N; r++) begin
      if ((k - r) >= 0 && (k - r) < N) begin
        row[r*DW +: DW] = a[((k - r)*N + r)*DW +: DW];
      end
    end
    return row;
  endfunction

  // Result row whose column-c sum reaches the bottom of the array in RUN cycle k.
  function automatic int cap_row(input int k, input int c);
    return k - c - LAT;
  endfunction

  assign accept = (state_q == S_IDLE) && start;

  // State register and all datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      w_q     <= '0;
      act_q   <= '0;
      vld_q   <= 1'b0;
      c_q     <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      w_q     <= w_d;
      act_q   <= act_d;
      vld_q   <= vld_d;
      c_q     <= c_d;
      cv_q    <= cv_d;
    end
  end

  // Next-state logic: IDLE -> LOAD -> RUN (RUN_LEN cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (k_q == KW'(RUN_LEN - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; act_row is computed one cycle ahead so it lands in cycle k.
  always_comb begin
    a_d   = a_q;
    w_d   = w_q;
    c_d   = c_q;
    cv_d  = cv_q;
    k_d   = '0;
    act_d = '0;
    vld_d = 1'b0;
    if (accept) begin
      a_d  = a_mat;
      w_d  = w_mat;
      cv_d = 1'b0;
    end
    if (state_q == S_RUN && state_d == S_RUN) begin
      k_d = k_q + KW'(1);
    end
    if (state_d == S_RUN) begin
      act_d = skew_row(a_q, int'(k_d));
      vld_d = (int'(k_d) <= 2*N - 2);
    end
    if (state_d == S_DONE) begin
      cv_d = 1'b1;
    end
    if (state_q == S_RUN) begin
      for (int c = 0; c < N; c++) begin
        if (cap_row(int'(k_q), c) >= 0 && cap_row(int'(k_q), c) < N) begin
          c_d[(cap_row(int'(k_q), c)*N + c)*AW +: AW] = col_sum[c*AW +: AW];
        end
      end
    end
  end

  // Output decode from the current state and registered datapath.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    w_load  = (state_q == S_LOAD);
    w_bus   = w_q;
    act_row = act_q;
    act_vld = vld_q;
    c_mat   = c_q;
    c_valid = cv_q;
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Testbench for systolic_seq_ctrl: drives jobs into the sequencer, closes the
// loop through a registered weight-stationary PE array model, and checks C
// against a plain matrix product plus the skew and timing rules.
module tb_systolic_seq_ctrl;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int AW  = 24;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              nrst;
  logic              start;
  logic [N*N*DW-1:0] a_mat;
  logic [N*N*DW-1:0] w_mat;
  logic              busy;
  logic              done;
  logic              w_load;
  logic [N*N*DW-1:0] w_bus;
  logic [N*DW-1:0]   act_row;
  logic              act_vld;
  logic [N*AW-1:0]   col_sum;
  logic [N*N*AW-1:0] c_mat;
  logic              c_valid;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_seq_ctrl #(.N(N), .DW(DW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .nrst(nrst), .start(start), .a_mat(a_mat), .w_mat(w_mat),
    .busy(busy), .done(done), .w_load(w_load), .w_bus(w_bus),
    .act_row(act_row), .act_vld(act_vld), .col_sum(col_sum),
    .c_mat(c_mat), .c_valid(c_valid)
  );

  always #5 clk = ~clk;

  // Registered PE array model: activations move right, partial sums move down.
  logic [DW-1:0] pw [N][N];
  logic [DW-1:0] pa [N][N];
  logic [AW-1:0] pp [N][N];
  logic [DW-1:0] pin [N][N];
  logic [AW-1:0] pabove [N][N];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      pin[r][0] = act_row[r*DW +: DW];
      for (int c = 1; c < N; c++) pin[r][c] = pa[r][c-1];
    end
    for (int c = 0; c < N; c++) begin
      pabove[0][c] = '0;
      for (int r = 1; r < N; r++) pabove[r][c] = pp[r-1][c];
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!nrst) begin
          pw[r][c] <= '0;
          pa[r][c] <= '0;
          pp[r][c] <= '0;
        end else begin
          if (w_load) pw[r][c] <= w_bus[(r*N + c)*DW +: DW];
          pa[r][c] <= pin[r][c];
          pp[r][c] <= pabove[r][c] + AW'(pin[r][c]) * AW'(pw[r][c]);
        end
      end
    end
  end

  always_comb begin
    col_sum = '0;
    for (int c = 0; c < N; c++) col_sum[c*AW +: AW] = pp[N-1][c];
  end

  // Matrix helpers and reference model.
  function automatic logic [N*N*DW-1:0] put(input logic [N*N*DW-1:0] m, input int i, input int j, input int v);
    m[(i*N + j)*DW +: DW] = DW'(v);
    return m;
  endfunction

  function automatic int el(input logic [N*N*DW-1:0] m, input int i, input int j);
    return int'(m[(i*N + j)*DW +: DW]);
  endfunction

  function automatic int cel(input logic [N*N*AW-1:0] m, input int i, input int j);
    return int'(m[(i*N + j)*AW +: AW]);
  endfunction

  function automatic logic [N*N*AW-1:0] ref_mm(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] w);
    logic [N*N*AW-1:0] c;
    int s;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int t = 0; t < N; t++) s += el(a, i, t) * el(w, t, j);
        c[(i*N + j)*AW +: AW] = AW'(s);
      end
    end
    return c;
  endfunction

  function automatic logic [N*DW-1:0] exp_row(input logic [N*N*DW-1:0] a, input int k);
    logic [N*DW-1:0] row;
    row = '0;
    for (int r = 0; r < N; r++) begin
      if (k - r >= 0 && k - r < N) row[r*DW +: DW] = DW'(el(a, k - r, r));
    end
    return row;
  endfunction

  function automatic logic [N*N*DW-1:0] rand_mat();
    logic [N*N*DW-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  function automatic logic [N*N*DW-1:0] seq_a();
    logic [N*N*DW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m = put(m, i, j, i*N + j + 1);
    return m;
  endfunction

  function automatic logic [N*N*DW-1:0] ident();
    logic [N*N*DW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m = put(m, i, i, 1);
    return m;
  endfunction

  // Per-job trace filled by run_job, indexed by cycles after the accept edge.
  int              tr_wload_cyc, tr_wload_cnt, tr_done_cyc;
  bit              tr_timeout;
  logic            tr_cv_load;
  logic [N*DW-1:0] tr_act [0:15];
  logic            tr_vld [0:15];

  // mode 0: plain pulse; 1: disturb inputs and re-pulse start mid-RUN; 2: hold start high.
  task automatic run_job(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] w, input int mode,
                         input logic [N*N*DW-1:0] a2, input logic [N*N*DW-1:0] w2);
    @(negedge clk);
    a_mat = a;
    w_mat = w;
    start = 1'b1;
    tr_wload_cyc = -1;
    tr_wload_cnt = 0;
    tr_done_cyc  = -1;
    tr_timeout   = 1'b1;
    tr_cv_load   = 1'bx;
    for (int i = 0; i < 16; i++) begin
      tr_act[i] = 'x;
      tr_vld[i] = 1'bx;
    end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && mode != 2) start = 1'b0;
      if (mode == 1 && cyc == 5) begin a_mat = a2; w_mat = w2; start = 1'b1; end
      if (mode == 1 && cyc == 6) start = 1'b0;
      if (mode == 2 && cyc == 3) begin a_mat = a2; w_mat = w2; end
      if (cyc == 1) tr_cv_load = c_valid;
      if (cyc < 16) begin
        tr_act[cyc] = act_row;
        tr_vld[cyc] = act_vld;
      end
      if (w_load) begin
        tr_wload_cnt++;
        if (tr_wload_cyc < 0) tr_wload_cyc = cyc;
      end
      if (done) begin
        tr_done_cyc = cyc;
        tr_timeout  = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_tests++;
    if ({busy, done, w_load, act_vld, c_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl: busy/done/w_load/act_vld/c_valid=%b required 00000", tag,
               {busy, done, w_load, act_vld, c_valid});
    end
    n_tests++;
    if (act_row !== '0 || w_bus !== '0 || c_mat !== '0) begin
      n_fail++;
      $display("FAIL %s_data: act_row=%h w_bus=%h c_mat=%h required all 0", tag, act_row, w_bus, c_mat);
    end
  endtask

  task automatic test_reset();
    nrst  = 1'b0;
    start = 1'b0;
    a_mat = rand_mat();
    w_mat = rand_mat();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    nrst = 1'b1;
  endtask

  task automatic test_identity();
    logic [N*N*DW-1:0] a;
    logic [N*N*AW-1:0] cexp;
    a = seq_a();
    run_job(a, ident(), 0, '0, '0);
    n_tests++;
    if (tr_timeout) begin n_fail++; $display("FAIL ident_timeout: done never seen, required at cycle 10"); end
    n_tests++;
    if (tr_wload_cyc != 1 || tr_wload_cnt != 1) begin
      n_fail++;
      $display("FAIL ident_wload: first at %0d count %0d, required at 1 count 1", tr_wload_cyc, tr_wload_cnt);
    end
    n_tests++;
    if (tr_done_cyc != 10) begin n_fail++; $display("FAIL ident_latency: done at %0d, required 10", tr_done_cyc); end
    cexp = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) cexp[(i*N + j)*AW +: AW] = AW'(i*N + j + 1);
    n_tests++;
    if (c_mat !== cexp) begin n_fail++; $display("FAIL ident_c: c_mat=%h required %h", c_mat, cexp); end
    n_tests++;
    if (c_valid !== 1'b1) begin n_fail++; $display("FAIL ident_cvalid_done: got %b required 1", c_valid); end
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      n_tests++;
      if (c_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || c_mat !== cexp) begin
        n_fail++;
        $display("FAIL ident_hold%0d: c_valid=%b done=%b busy=%b c_mat=%h required 1 0 0 %h",
                 t, c_valid, done, busy, c_mat, cexp);
      end
    end
  endtask

  task automatic test_skew();
    int tbl [5][3] = '{'{1,0,0}, '{4,2,0}, '{7,5,3}, '{0,8,6}, '{0,0,9}};
    logic [N*DW-1:0] exp;
    run_job(seq_a(), rand_mat(), 0, '0, '0);
    for (int k = 0; k < 2*N - 2 + LAT + 1; k++) begin
      exp = '0;
      if (k < 5) for (int r = 0; r < N; r++) exp[r*DW +: DW] = DW'(tbl[k][r]);
      n_tests++;
      if (tr_act[k+2] !== exp || tr_vld[k+2] !== (k <= 4)) begin
        n_fail++;
        $display("FAIL skew_k%0d: act_row=%h act_vld=%b required %h %b", k, tr_act[k+2], tr_vld[k+2], exp, k <= 4);
      end
    end
    n_tests++;
    if (tr_act[1] !== '0 || tr_vld[1] !== 1'b0 || tr_act[10] !== '0 || tr_vld[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL skew_idle_rows: load=%h/%b done=%h/%b required 0/0", tr_act[1], tr_vld[1], tr_act[10], tr_vld[10]);
    end
  endtask

  task automatic test_max();
    logic [N*N*DW-1:0] m;
    m = '1;
    run_job(m, m, 0, '0, '0);
    n_tests++;
    if (tr_timeout) begin n_fail++; $display("FAIL max_timeout: done never seen, required at cycle 10"); end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        n_tests++;
        if (cel(c_mat, i, j) != 195075) begin
          n_fail++;
          $display("FAIL max_c%0d%0d: got %0d required 195075", i, j, cel(c_mat, i, j));
        end
      end
    end
  endtask

  task automatic test_matmul();
    int cx [3][3] = '{'{10,2,5}, '{22,5,14}, '{34,8,23}};
    logic [N*N*DW-1:0] w;
    w = '0;
    w = put(w, 0, 0, 1); w = put(w, 0, 2, 2);
    w = put(w, 1, 1, 1);
    w = put(w, 2, 0, 3); w = put(w, 2, 2, 1);
    run_job(seq_a(), w, 0, '0, '0);
    n_tests++;
    if (tr_cv_load !== 1'b0) begin n_fail++; $display("FAIL mm_cvalid_load: got %b required 0", tr_cv_load); end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (cel(c_mat, i, 0) != cx[i][0] || cel(c_mat, i, 1) != cx[i][1] || cel(c_mat, i, 2) != cx[i][2]) begin
        n_fail++;
        $display("FAIL mm_row%0d: got %0d,%0d,%0d required %0d,%0d,%0d", i,
                 cel(c_mat, i, 0), cel(c_mat, i, 1), cel(c_mat, i, 2), cx[i][0], cx[i][1], cx[i][2]);
      end
    end
  endtask

  task automatic test_random();
    logic [N*N*DW-1:0] a, w;
    int bad;
    for (int job = 0; job < 6; job++) begin
      a = rand_mat();
      w = rand_mat();
      run_job(a, w, 0, '0, '0);
      n_tests++;
      if (tr_done_cyc != 10 || c_mat !== ref_mm(a, w)) begin
        n_fail++;
        $display("FAIL rand%0d_c: done at %0d c_mat=%h required 10 %h", job, tr_done_cyc, c_mat, ref_mm(a, w));
      end
      bad = 0;
      for (int k = 0; k < 8; k++) if (tr_act[k+2] !== exp_row(a, k)) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL rand%0d_skew: %0d wrong RUN cycles required 0", job, bad); end
    end
  endtask

  task automatic test_ignore();
    logic [N*N*DW-1:0] a, w;
    a = rand_mat();
    w = rand_mat();
    run_job(a, w, 1, rand_mat(), rand_mat());
    n_tests++;
    if (tr_done_cyc != 10 || c_mat !== ref_mm(a, w) || w_bus !== w) begin
      n_fail++;
      $display("FAIL ignore_c: done at %0d c_mat=%h w_bus=%h required 10 %h %h",
               tr_done_cyc, c_mat, w_bus, ref_mm(a, w), w);
    end
    for (int t = 11; t <= 12; t++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || w_load !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_noqueue_cyc%0d: busy=%b w_load=%b required 0 0", t, busy, w_load);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*N*DW-1:0] a, w, a2, w2;
    int cnt;
    a = rand_mat(); w = rand_mat(); a2 = rand_mat(); w2 = rand_mat();
    run_job(a, w, 2, a2, w2);
    n_tests++;
    if (tr_done_cyc != 10 || c_mat !== ref_mm(a, w)) begin
      n_fail++;
      $display("FAIL b2b_job1: done at %0d c_mat=%h required 10 %h", tr_done_cyc, c_mat, ref_mm(a, w));
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || c_valid !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: busy=%b c_valid=%b done=%b required 0 1 0", busy, c_valid, done);
    end
    @(negedge clk);
    n_tests++;
    if (w_load !== 1'b1 || c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load: w_load=%b c_valid=%b required 1 0", w_load, c_valid);
    end
    start = 1'b0;
    a_mat = rand_mat();
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (done) break;
    end
    n_tests++;
    if (cnt != 9 || c_mat !== ref_mm(a2, w2)) begin
      n_fail++;
      $display("FAIL b2b_job2: done %0d after LOAD c_mat=%h required 9 %h", cnt, c_mat, ref_mm(a2, w2));
    end
  endtask

  task automatic test_abort();
    logic [N*N*DW-1:0] a, w;
    @(negedge clk);
    a_mat = rand_mat();
    w_mat = rand_mat();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || act_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_midrun: busy=%b act_vld=%b required 1 1", busy, act_vld);
    end
    nrst = 1'b0;
    @(negedge clk);
    check_zero_outputs("abort");
    nrst = 1'b1;
    a = rand_mat();
    w = rand_mat();
    run_job(a, w, 0, '0, '0);
    n_tests++;
    if (tr_done_cyc != 10 || c_mat !== ref_mm(a, w)) begin
      n_fail++;
      $display("FAIL abort_fresh: done at %0d c_mat=%h required 10 %h", tr_done_cyc, c_mat, ref_mm(a, w));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_max();
    test_matmul();
    test_random();
    test_ignore();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
